// File: rtl/pll_clk_rst_mgr.sv
// Post-PLL clock/reset manager: qualifies PLL lock, sequences per-domain reset release,
// drives programmable clock-enable / divided-clock outputs and counts lock losses.
module pll_clk_rst_mgr #(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int LOCK_CYC = 1024,
  parameter int SEQ_GAP  = 16,
  parameter logic [NCH*DW-1:0] DIV_INIT = '0,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              div_wr,
  input  logic [SW-1:0]     div_sel,
  input  logic [DW-1:0]     div_val,
  output logic [NCH-1:0]    ce,
  output logic [NCH-1:0]    ck_div,
  output logic [NCH-1:0]    rst_out_n,
  output logic              ready,
  output logic [7:0]        lock_loss_cnt
);

  localparam int LW = $clog2(LOCK_CYC);
  localparam int GW = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, SEQ, RUN} state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic            lock_s;
  logic            drop;
  logic [LW-1:0]   lock_cnt_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic [SW-1:0]   idx_reg;
  logic [NCH-1:0]  rst_out_reg;
  logic            ready_reg;
  logic [7:0]      loss_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pll_lock};
    end
  end

  assign lock_s = sync_reg[1];
  // Lock lost anywhere past WAIT_LOCK: dividers must clear on the same edge as the resets.
  assign drop   = (state_reg != WAIT_LOCK) && !lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WAIT_LOCK;
      lock_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      idx_reg      <= '0;
      rst_out_reg  <= '0;
      ready_reg    <= 1'b0;
      loss_cnt_reg <= '0;
    end else if (drop) begin
      state_reg   <= WAIT_LOCK;
      rst_out_reg <= '0;
      ready_reg   <= 1'b0;
      if (state_reg == RUN && loss_cnt_reg != 8'hFF) begin
        loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_reg    <= STABLE;
            lock_cnt_reg <= '0;
          end
        end
        STABLE: begin
          if (lock_cnt_reg == LW'(LOCK_CYC - 1)) begin
            state_reg   <= SEQ;
            gap_cnt_reg <= '0;
            idx_reg     <= '0;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + LW'(1);
          end
        end
        SEQ: begin
          // gap_cnt counts down between releases; idx walks the channels in order.
          if (gap_cnt_reg == '0) begin
            rst_out_reg[idx_reg] <= 1'b1;
            if (idx_reg == SW'(NCH - 1)) begin
              state_reg <= RUN;
            end else begin
              idx_reg     <= idx_reg + SW'(1);
              gap_cnt_reg <= GW'(SEQ_GAP - 1);
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
          end
        end
        RUN: begin
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_out_n     = rst_out_reg;
  assign ready         = ready_reg;
  assign lock_loss_cnt = loss_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_div
      logic [DW-1:0] shadow_reg;
      logic [DW-1:0] act_reg;
      logic [DW-1:0] cnt_reg;
      logic          ce_reg;
      logic          ck_reg;
      logic          run;
      logic          wrap;

      assign run  = rst_out_reg[gi] && !drop;
      assign wrap = (cnt_reg == act_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= DIV_INIT[gi*DW +: DW];
        end else if (div_wr && div_sel == SW'(gi)) begin
          shadow_reg <= div_val;
        end
      end

      // Active divisor only changes at a wrap or while held, so ck_div periods stay whole.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_reg <= DIV_INIT[gi*DW +: DW];
          cnt_reg <= '0;
          ce_reg  <= 1'b0;
          ck_reg  <= 1'b0;
        end else if (!run) begin
          act_reg <= shadow_reg;
          cnt_reg <= '0;
          ce_reg  <= 1'b0;
          ck_reg  <= 1'b0;
        end else if (wrap) begin
          act_reg <= shadow_reg;
          cnt_reg <= '0;
          ce_reg  <= 1'b1;
          ck_reg  <= ~ck_reg;
        end else begin
          cnt_reg <= cnt_reg + DW'(1);
          ce_reg  <= 1'b0;
        end
      end

      assign ce[gi]     = ce_reg;
      assign ck_div[gi] = ck_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pll_clk_rst_mgr.sv
// Scoreboard bench for pll_clk_rst_mgr: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_clk_rst_mgr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       div_wr = 1'b0;
  logic [1:0] div_sel = '0;
  logic [7:0] div_val = '0;
  logic [3:0] ce;
  logic [3:0] ck_div;
  logic [3:0] rst_out_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int b, d, r, g;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pll_clk_rst_mgr #(
    .NCH(4), .DW(8), .LOCK_CYC(16), .SEQ_GAP(4), .DIV_INIT(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
    .ce(ce), .ck_div(ck_div), .rst_out_n(rst_out_n),
    .ready(ready), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  function automatic string kname(int k);
    case (k)
      0: return "rst_out_n";
      1: return "ready";
      2: return "ce";
      3: return "ck_div";
      4: return "lock_loss_cnt";
      5: return "ck_div1";
      default: return "ce1";
    endcase
  endfunction

  function automatic int sample(int k);
    case (k)
      0: return int'(rst_out_n);
      1: return int'(ready);
      2: return int'(ce);
      3: return int'(ck_div);
      4: return int'(lock_loss_cnt);
      5: return int'(ck_div[1]);
      default: return int'(ce[1]);
    endcase
  endfunction

  // Sorted insert keeps the queue ordered by cycle regardless of push order.
  function automatic void expect_at(int c, int k, int v);
    exp_t e;
    int i;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endfunction

  // Release timing after pll_lock rises at cycle s (LOCK_CYC=16, SEQ_GAP=4).
  function automatic void expect_seq(int s, int llc);
    expect_at(s + 19, 0, 4'b0000);
    expect_at(s + 20, 0, 4'b0001);
    expect_at(s + 23, 0, 4'b0001);
    expect_at(s + 24, 0, 4'b0011);
    expect_at(s + 27, 0, 4'b0011);
    expect_at(s + 28, 0, 4'b0111);
    expect_at(s + 31, 0, 4'b0111);
    expect_at(s + 32, 0, 4'b1111);
    expect_at(s + 32, 1, 0);
    expect_at(s + 33, 1, 1);
    expect_at(s + 33, 4, llc);
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc)
        chk($sformatf("%s@%0d missed", kname(mon_e.kind), mon_e.cyc), cyc, mon_e.cyc);
      else
        chk($sformatf("%s@%0d", kname(mon_e.kind), mon_e.cyc), sample(mon_e.kind), mon_e.val);
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic div_write(int sel, int val);
    div_sel = 2'(sel);
    div_val = 8'(val);
    div_wr  = 1'b1;
    @(posedge clk);
    #1;
    div_wr  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst_out_n", int'(rst_out_n), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_ce", int'(ce), 0);
    chk("reset_ck_div", int'(ck_div), 0);
    chk("reset_lock_loss_cnt", int'(lock_loss_cnt), 0);
    rst_n = 1'b1;
    wait_cyc(cyc + 3);

    // T1 power-up; DIV_INIT=0 so released channels pulse ce every cycle
    pll_lock = 1'b1;
    b = cyc;
    expect_seq(b, 0);
    expect_at(b + 20, 2, 4'b0000);
    expect_at(b + 21, 2, 4'b0001);
    expect_at(b + 21, 3, 4'b0001);
    expect_at(b + 22, 3, 4'b0000);
    expect_at(b + 23, 3, 4'b0001);
    wait_cyc(b + 40);

    // T3 loss in RUN
    pll_lock = 1'b0;
    d = cyc;
    expect_at(d + 2, 0, 4'b1111);
    expect_at(d + 2, 1, 1);
    expect_at(d + 2, 2, 4'b1111);
    expect_at(d + 3, 0, 4'b0000);
    expect_at(d + 3, 1, 0);
    expect_at(d + 3, 2, 4'b0000);
    expect_at(d + 3, 3, 4'b0000);
    expect_at(d + 3, 4, 1);

    // T4 divisors written while the domains are held
    wait_cyc(d + 5);
    div_write(1, 2);
    div_write(2, 0);
    wait_cyc(d + 10);
    pll_lock = 1'b1;
    r = cyc;
    expect_seq(r, 1);
    expect_at(r + 26, 2, 4'b0001);
    expect_at(r + 27, 2, 4'b0011);
    expect_at(r + 28, 2, 4'b0001);
    expect_at(r + 29, 2, 4'b0101);
    expect_at(r + 30, 2, 4'b0111);
    expect_at(r + 31, 2, 4'b0101);
    expect_at(r + 33, 2, 4'b1111);
    expect_at(r + 34, 2, 4'b1101);
    expect_at(r + 26, 5, 0);
    expect_at(r + 27, 5, 1);
    expect_at(r + 29, 5, 1);
    expect_at(r + 30, 5, 0);
    expect_at(r + 32, 5, 0);
    expect_at(r + 33, 5, 1);

    // T5 live changes: D=5 at r+40, D=1 mid-period at r+50, D=3 on the wrap at r+60
    expect_at(r + 42, 6, 1);
    expect_at(r + 43, 6, 0);
    expect_at(r + 47, 6, 0);
    expect_at(r + 48, 6, 1);
    expect_at(r + 49, 6, 0);
    expect_at(r + 49, 2, 4'b1101);
    expect_at(r + 53, 6, 0);
    expect_at(r + 54, 6, 1);
    expect_at(r + 55, 6, 0);
    expect_at(r + 56, 6, 1);
    expect_at(r + 57, 6, 0);
    expect_at(r + 58, 6, 1);
    expect_at(r + 60, 6, 1);
    expect_at(r + 61, 6, 0);
    expect_at(r + 62, 6, 1);
    expect_at(r + 63, 6, 0);
    expect_at(r + 65, 6, 0);
    expect_at(r + 66, 6, 1);
    expect_at(r + 47, 5, 0);
    expect_at(r + 48, 5, 1);
    expect_at(r + 53, 5, 1);
    expect_at(r + 54, 5, 0);
    expect_at(r + 55, 5, 0);
    expect_at(r + 56, 5, 1);
    expect_at(r + 57, 5, 1);
    expect_at(r + 58, 5, 0);
    expect_at(r + 65, 5, 0);
    expect_at(r + 66, 5, 1);
    wait_cyc(r + 39);
    div_write(1, 5);
    wait_cyc(r + 49);
    div_write(1, 1);
    wait_cyc(r + 59);
    div_write(1, 3);
    wait_cyc(r + 70);

    // Second drop from RUN, then 256 more to reach saturation
    pll_lock = 1'b0;
    wait_cyc(cyc + 5);
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b1;
      wait_cyc(cyc + 36);
      pll_lock = 1'b0;
      if (i == 100 || i == 251 || i == 252 || i == 255)
        expect_at(cyc + 3, 4, (i + 3 > 255) ? 255 : i + 3);
      wait_cyc(cyc + 5);
    end

    // T6 asynchronous reset mid-sequence
    pll_lock = 1'b1;
    b = cyc;
    expect_at(b + 25, 0, 4'b0011);
    wait_cyc(b + 26);
    #1;
    rst_n = 1'b0;
    pll_lock = 1'b0;
    #1;
    chk("async_rst_out_n", int'(rst_out_n), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_ce", int'(ce), 0);
    chk("async_ck_div", int'(ck_div), 0);
    chk("async_lock_loss_cnt", int'(lock_loss_cnt), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(cyc + 3);

    // T2 glitch during STABLE restarts the window; ch1 back at DIV_INIT (D=0)
    pll_lock = 1'b1;
    g = cyc;
    expect_at(g + 30, 0, 4'b0000);
    expect_at(g + 31, 0, 4'b0001);
    expect_at(g + 35, 0, 4'b0011);
    expect_at(g + 36, 2, 4'b0011);
    expect_at(g + 37, 2, 4'b0011);
    expect_at(g + 43, 1, 0);
    expect_at(g + 44, 1, 1);
    expect_at(g + 44, 4, 0);
    wait_cyc(g + 10);
    pll_lock = 1'b0;
    wait_cyc(g + 11);
    pll_lock = 1'b1;
    wait_cyc(g + 50);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
